counter_ctrl: RTL
=================

# counter_ctrl

Run/pause/clear sequencer for the two-digit BCD counter datapath on the DE10-Lite board. It debounces the two push-buttons and samples the slide switches. A prescaler divides the 50 MHz board clock into one-cycle count-enable ticks. The block issues clear, load and enable strobes to the counters, whose HEX displays show the result. It sits between the board I/O and the BCD counter chain and is the only source of counter control strobes.

## Interface
- TICK_DIV, 50_000_000, clock cycles per count tick (1 Hz at 50 MHz); minimum 2
- DB_CYCLES, 500_000, cycles a synchronized key level must be stable to be accepted (10 ms); minimum 1
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- key  in  2  raw push-buttons, active-low; key[0] start/stop, key[1] clear
- sw  in  10  sw[9] direction (1 up, 0 down); sw[8] preload enable; sw[7:0] preload value, two BCD digits
- tc  in  1  terminal count from datapath (99 counting up, 00 counting down)
- cnt_en  out  1  one-cycle count-enable tick
- cnt_clr  out  1  one-cycle clear strobe
- cnt_load  out  1  one-cycle load strobe
- load_val  out  8  value for cnt_load, valid while cnt_load high
- cnt_up  out  1  count direction, latched
- state_o  out  2  current FSM state
- run_led  out  1  high while in RUN

## Operation
- Key path: 2-FF synchronizer, then a stability counter. The debounced level updates only after DB_CYCLES consecutive equal samples. A debounced 1→0 transition yields a one-cycle press pulse (start_p, clear_p). Release generates nothing.
- FSM states: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- IDLE:
  - start_p → RUN.
  - cnt_up latched from sw[9].
  - If sw[8]=1, cnt_load=1 and load_val=sw[7:0].
  - Prescaler cleared.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - At TICK_DIV-1: if tc=0, cnt_en=1; if tc=1, no cnt_en and next state DONE.
  - start_p → PAUSE.
- PAUSE:
  - Prescaler holds its value.
  - start_p → RUN, resuming from the held value.
- DONE: start_p ignored.
- clear_p in any state: cnt_clr=1, next state IDLE, prescaler cleared.
- Simultaneous events, in priority order:
  - clear_p beats start_p.
  - clear_p suppresses a same-cycle tick, so cnt_en=0.
  - start_p (RUN→PAUSE) coinciding with a tick: the tick still issues cnt_en.
- sw[9:8] and sw[7:0] changes outside the IDLE→RUN transition have no effect.
- load_val is 0 whenever cnt_load=0.
- Invalid BCD in sw[7:0] is passed through unchecked.

## Timing
- All outputs registered; no combinational input-to-output path.
- Reset values:
  - state IDLE, state_o=0.
  - cnt_en=cnt_clr=cnt_load=0, load_val=0, run_led=0.
  - cnt_up=1.
  - Prescaler and debounce counters 0.
  - Debounced levels 1 (released).
- Key press latency: press pulse 2 (sync) + DB_CYCLES cycles after the raw edge. The registered strobe or state change appears 1 cycle later.
- cnt_load is asserted in the same cycle state_o first reads RUN.
- First cnt_en is exactly TICK_DIV cycles after state_o first reads RUN, then every TICK_DIV cycles.
- Reset mid-operation: next edge forces the reset values, and any in-flight debounce count is discarded.
- Strobes never overlap: cnt_clr, cnt_load and cnt_en are pairwise exclusive.
  - The cnt_load/cnt_en exclusivity holds because TICK_DIV ≥ 2.

## Structure
- Shared package counter_ctrl_pkg:
  - state encodings IDLE/RUN/PAUSE/DONE
  - default TICK_DIV, DB_CYCLES
  - key index constants KEY_START=0, KEY_CLEAR=1
- One sub-module, key_debounce: synchronizer, stability counter and falling-edge pulse, parameterized by DB_CYCLES. Instantiated once per key.
- Prescaler and FSM live in counter_ctrl.

## Test plan
(TICK_DIV=4, DB_CYCLES=3 throughout.)
1. Reset held 2 cycles, then released → all outputs at reset values and state_o=0. A 2-cycle key[0] glitch produces no state change.
2. key[0] low for 10 cycles, sw=10'b10_0000_0000 → RUN one cycle after the press pulse, cnt_up=1, no cnt_load. cnt_en at +4, +8, +12 cycles.
3. sw=10'b01_0100_0010, start → cnt_load=1 with load_val=8'h42 on RUN entry; cnt_up=0. Pause after 1 tick and hold 20 cycles → no cnt_en. Restart → next cnt_en after the remaining prescaler count.
4. RUN with tc=1 at a tick → no cnt_en, state_o=3. A further start press leaves state_o=3.
5. key[0] and key[1] pressed together in RUN → cnt_clr=1 for one cycle, state_o=0, no PAUSE.
6. Clear press pulse aligned with prescaler=3 → cnt_en=0 and cnt_clr=1. Reset asserted mid-debounce → no press pulse after release.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// ============================================================================
//  Module      : counter_ctrl_pkg
//  Description : Shared definitions for the run/pause/clear sequencer of the
//                two-digit BCD counter: FSM state encodings, default timing
//                parameters and push-button index constants.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_ctrl_pkg;

    // Sequencer states, also exported on state_o
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // 1 Hz count tick and 10 ms debounce window at a 50 MHz board clock
    localparam int TICK_DIV_DEFAULT  = 50_000_000;
    localparam int DB_CYCLES_DEFAULT = 500_000;

    // Push-button positions on the key bus
    localparam int KEY_START = 0;
    localparam int KEY_CLEAR = 1;

endpackage : counter_ctrl_pkg

`default_nettype wire

// File: rtl/counter_ctrl_if.sv
// ============================================================================
//  Module      : counter_ctrl_if
//  Description : Board-side and datapath-side signal bundle of counter_ctrl.
//                master : the sequencer (consumes key/sw/tc, drives strobes)
//                slave  : board I/O plus BCD counter chain
//  Signals     : key[1:0] raw active-low buttons, sw[9:0] slide switches,
//                tc terminal count, cnt_en/cnt_clr/cnt_load strobes,
//                load_val[7:0], cnt_up, state_o[1:0], run_led
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface counter_ctrl_if;

    logic [1:0] key;
    logic [9:0] sw;
    logic       tc;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cnt_load;
    logic [7:0] load_val;
    logic       cnt_up;
    logic [1:0] state_o;
    logic       run_led;

    modport master (
        input  key, sw, tc,
        output cnt_en, cnt_clr, cnt_load, load_val, cnt_up, state_o, run_led
    );

    modport slave (
        output key, sw, tc,
        input  cnt_en, cnt_clr, cnt_load, load_val, cnt_up, state_o, run_led
    );

endinterface : counter_ctrl_if

`default_nettype wire

// File: rtl/counter_ctrl_key_debounce.sv
// ============================================================================
//  Module      : key_debounce
//  Description : Debouncer for one active-low push-button. Two-flop
//                synchronizer, stability counter, and a one-cycle pulse on an
//                accepted press (debounced 1->0). Releases produce nothing.
//  Ports       : clk, rst       clock, synchronous active-high reset
//                i_key_n        raw button level (active-low)
//                o_press        one-cycle registered press pulse
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key_n,
    output logic      o_press
);

    // Counter only has to reach DB_CYCLES-1; +1 keeps the width >= 1 for DB_CYCLES=1
    localparam int c_CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // r_cnt counts consecutive synchronized samples that disagree with
            // the accepted level; any agreeing sample restarts the window.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_press = r_press;

endmodule : key_debounce

`default_nettype wire

// File: rtl/counter_ctrl.sv
// ============================================================================
//  Module      : counter_ctrl
//  Description : Run/pause/clear sequencer for the two-digit BCD counter.
//                Debounces start/stop and clear buttons, prescales the clock
//                into count ticks and issues mutually exclusive clear, load
//                and enable strobes. All outputs are registered.
//  Ports       : clk, reset     clock, synchronous active-high reset
//                bus (master)   key/sw/tc in; cnt_en, cnt_clr, cnt_load,
//                               load_val, cnt_up, state_o, run_led out
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  wire logic      clk,
    input  wire logic      reset,
    counter_ctrl_if.master bus
);

    localparam int c_PRESC_W = $clog2(TICK_DIV);
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);

    logic [1:0] w_press;
    logic       w_start_p;
    logic       w_clear_p;

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst     (reset),
            .i_key_n (bus.key[k]),
            .o_press (w_press[k])
        );
    end

    assign w_start_p = w_press[KEY_START];
    assign w_clear_p = w_press[KEY_CLEAR];

    logic [1:0]           r_state;
    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_cnt_en;
    logic                 r_cnt_clr;
    logic                 r_cnt_load;
    logic [7:0]           r_load_val;
    logic                 r_cnt_up;
    logic                 r_run_led;

    logic [1:0]           w_state_nxt;
    logic [c_PRESC_W-1:0] w_presc_nxt;
    logic                 w_cnt_en_nxt;
    logic                 w_cnt_clr_nxt;
    logic                 w_cnt_load_nxt;
    logic [7:0]           w_load_val_nxt;
    logic                 w_cnt_up_nxt;
    logic                 w_run_led_nxt;
    logic                 w_tick;
    logic                 w_start_run;

    // Last prescaler cycle of a RUN period
    assign w_tick      = (r_state == RUN) && (r_presc == c_PRESC_LAST);
    // IDLE->RUN launch; the only moment the switches are looked at
    assign w_start_run = (r_state == IDLE) && w_start_p && !w_clear_p;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_presc    <= '0;
            r_cnt_en   <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_cnt_load <= 1'b0;
            r_load_val <= 8'h00;
            r_cnt_up   <= 1'b1;
            r_run_led  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_cnt_en   <= w_cnt_en_nxt;
            r_cnt_clr  <= w_cnt_clr_nxt;
            r_cnt_load <= w_cnt_load_nxt;
            r_load_val <= w_load_val_nxt;
            r_cnt_up   <= w_cnt_up_nxt;
            r_run_led  <= w_run_led_nxt;
        end
    end

    // Next state: clear dominates everything; a terminal tick beats a
    // same-cycle stop request so a finished count never lands in PAUSE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear_p) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start_p) w_state_nxt = RUN;
                RUN: begin
                    if (w_tick && bus.tc)  w_state_nxt = DONE;
                    else if (w_start_p)    w_state_nxt = PAUSE;
                end
                PAUSE:   if (w_start_p) w_state_nxt = RUN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Output and prescaler next values
    always_comb begin
        w_cnt_en_nxt   = w_tick && !bus.tc && !w_clear_p;
        w_cnt_clr_nxt  = w_clear_p;
        w_cnt_load_nxt = w_start_run && bus.sw[8];
        w_load_val_nxt = w_cnt_load_nxt ? bus.sw[7:0] : 8'h00;
        w_cnt_up_nxt   = w_start_run ? bus.sw[9] : r_cnt_up;
        w_run_led_nxt  = (w_state_nxt == RUN);

        // Prescaler advances only in RUN; PAUSE (and DONE) hold it
        w_presc_nxt = r_presc;
        if (w_clear_p || (r_state == IDLE)) begin
            w_presc_nxt = '0;
        end else if (r_state == RUN) begin
            w_presc_nxt = w_tick ? '0 : r_presc + c_PRESC_W'(1);
        end
    end

    assign bus.cnt_en   = r_cnt_en;
    assign bus.cnt_clr  = r_cnt_clr;
    assign bus.cnt_load = r_cnt_load;
    assign bus.load_val = r_load_val;
    assign bus.cnt_up   = r_cnt_up;
    assign bus.state_o  = r_state;
    assign bus.run_led  = r_run_led;

endmodule : counter_ctrl

`default_nettype wire
